apb_master_arb: RTL and testbench
=================================

# apb_master_arb

Two-port APB master with round-robin arbitration. It shares one APB bus, and the peripheral slaves behind it (I2C bridge at 0x8000_0000 and others), between two local requesters. Each granted request becomes one complete APB transfer: SETUP, ACCESS with pready/timeout, then an optional read-latency wait, because slaves register prdata one cycle after ACCESS. The result is returned to the requester with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles after ACCESS completion before prdata is sampled on reads (0..7)
- TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort (2..255)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  transfer request, level, held until doneN
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  transfer address
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with doneN; 1 = timeout abort
- rdata0 / rdata1  out  DATA_W  read data, registered, valid from doneN onward
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready; tie high for slaves without it

## Operation
- FSM states: IDLE, SETUP, ACCESS, LAT, DONE.
- IDLE:
  - If any req is high, arbitrate and latch the winner's addr/wdata/we into paddr/pwdata/pwrite and into an owner register, then go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration is round-robin with a last-grant pointer (reset = 1, so port 0 wins the first tie).
  - If only one port requests, it wins.
  - If both request, the port that is not the last-granted one wins.
  - The pointer updates on every grant.
- SETUP: psel=1, penable=0. Always one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. A cycle counter counts ACCESS cycles.
  - pready=1: write → DONE; read with RD_LAT=0 → sample prdata into rdata[owner], then DONE; read with RD_LAT>0 → LAT.
  - pready=0 in the TIMEOUT-th consecutive cycle → DONE with the error flag set. rdata is unchanged.
- LAT: psel=0, penable=0. Hold for RD_LAT cycles. At the edge ending the last LAT cycle, sample prdata into rdata[owner], then go to DONE.
- DONE: psel=0. done[owner]=1 and err[owner]=flag for exactly one cycle, then IDLE.
- Requester rule: deassert req at the edge where done is sampled high. If req is still high in IDLE, it is a new request.
- paddr, pwdata and pwrite hold their last value outside a transfer. They are stable from SETUP through the end of ACCESS.
- The non-owner's rdata, done and err are never disturbed.
- req, we, addr and wdata are sampled only in IDLE; changes mid-transfer are ignored.

## Timing
- Reset (async, immediate): state=IDLE, pointer=1. psel, penable, pwrite, paddr, pwdata, done0/1, err0/1, rdata0/1 all 0. No done pulse for an aborted transfer.
- req seen in IDLE at cycle t:
  - SETUP at t+1, ACCESS at t+2.
  - Write with pready=1: DONE at t+3.
  - Read with RD_LAT=1: LAT at t+3, DONE at t+4.
- Each pready-low cycle adds one cycle.
- Timeout: DONE follows TIMEOUT ACCESS cycles, i.e. DONE at t+2+TIMEOUT.
- Back-to-back: minimum 4 cycles per write (IDLE, SETUP, ACCESS, DONE). psel deasserts for at least one cycle between transfers.
- Simultaneous req0 and req1 in the same IDLE cycle are arbitrated by the pointer. The loser waits and is granted in the next IDLE if its req is still high.
- A req arriving during a transfer waits for IDLE.

## Test plan
- Single write, port 0, addr 0x8000_0000, data 0xA5A5_0001, pready=1 → psel high t+1..t+2, penable high t+2 only, pwrite=1, done0 at t+3, err0=0.
- Single read, port 1, RD_LAT=1, slave drives prdata=0x1234_5678 one cycle after ACCESS → rdata1=0x1234_5678 with done1 at t+4. rdata0 stays 0.
- req0 and req1 high continuously after reset → grants alternate 0,1,0,1. Each done pulses once per transfer. No transfer is starved.
- Write with pready low for 3 ACCESS cycles then high → ACCESS lasts 4 cycles, paddr/pwdata stable throughout, done at t+6, err=0.
- Read with pready held low, TIMEOUT=16 → DONE at t+18, err=1, rdata unchanged, psel drops.
- Assert reset during ACCESS → psel, penable and done drop immediately. After release, a pending req0 starts a fresh SETUP.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin grant, one SETUP/ACCESS transfer per grant,
// optional read-latency wait, then a one-cycle done/err pulse back to the owner.
//   state  | meaning
//   IDLE   | arbitrate pending requests, latch winner's command onto the bus
//   SETUP  | psel=1, penable=0
//   ACCESS | psel=1, penable=1, wait for pready or timeout
//   LAT    | read latency wait before sampling prdata
//   DONE   | done/err pulse to the owner
module apb_master_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_LAT, S_DONE} state_t;

    localparam logic [7:0] ACC_LOAD = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [7:0]        acc_cnt_q, acc_cnt_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic gnt;
    logic finish;
    logic timeout_hit;
    logic sample_rd;

    // With both requesting, the port that did not win last time goes next.
    assign gnt = (req0 && req1) ? ~last_gnt_q : req1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        acc_cnt_d   = acc_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        sample_rd   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = gnt;
                    last_gnt_d = gnt;
                    paddr_d    = gnt ? addr1  : addr0;
                    pwdata_d   = gnt ? wdata1 : wdata0;
                    pwrite_d   = gnt ? we1    : we0;
                    psel_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                acc_cnt_d = ACC_LOAD;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    if (pwrite_q) begin
                        finish = 1'b1;
                    end else if (RD_LAT == 0) begin
                        sample_rd = 1'b1;
                        finish    = 1'b1;
                    end else begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        lat_cnt_d = LAT_LOAD;
                        state_d   = S_LAT;
                    end
                end else if (acc_cnt_q == 8'd0) begin
                    finish      = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q - 8'd1;
                end
            end
            S_LAT: begin
                if (lat_cnt_q == 3'd0) begin
                    sample_rd = 1'b1;
                    finish    = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample_rd) begin
            if (owner_q) rdata1_d = prdata;
            else         rdata0_d = prdata;
        end
        if (finish) begin
            done_d[owner_q] = 1'b1;
            err_d[owner_q]  = timeout_hit;
            psel_d          = 1'b0;
            penable_d       = 1'b0;
            state_d         = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            acc_cnt_q  <= '0;
            lat_cnt_q  <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            acc_cnt_q  <= acc_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: scenario tasks against a slave model with a
// register map and a requester-side expected memory.
module tb_apb_master_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite, psel, penable;
    logic [DW-1:0] prdata;
    logic          pready;

    apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] exp_mem   [logic [31:0]];
    int fixed_waits = 0;
    int wait_left   = 0;
    int cur_waits   = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] exp_lookup(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    // Slave: inserts wait states per transfer, returns read data one cycle after ACCESS.
    initial begin
        bit          acc_ok_prev;
        logic        prev_we;
        logic [31:0] prev_addr, prev_wdata;
        acc_ok_prev = 0;
        prev_we     = 0;
        prev_addr   = 0;
        prev_wdata  = 0;
        pready      = 0;
        prdata      = 0;
        forever begin
            @(posedge clk);
            #1;
            prdata = $urandom;
            if (reset) begin
                pready      = 0;
                acc_ok_prev = 0;
                wait_left   = 0;
            end else begin
                if (acc_ok_prev) begin
                    if (prev_we) slave_mem[prev_addr] = prev_wdata;
                    else prdata = slave_mem.exists(prev_addr) ? slave_mem[prev_addr] : dflt(prev_addr);
                end
                if (psel && !penable) begin
                    wait_left = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 2));
                    cur_waits = wait_left;
                end
                if (psel && penable) begin
                    if (wait_left > 0) begin
                        pready = 0;
                        wait_left--;
                    end else begin
                        pready = 1;
                    end
                end else begin
                    pready = 0;
                end
                acc_ok_prev = psel && penable && pready;
                prev_we     = pwrite;
                prev_addr   = paddr;
                prev_wdata  = pwdata;
            end
        end
    end

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic wait_any_done(output int p, output int when, output bit ok);
        ok = 0; p = 0; when = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                p    = done1 ? 1 : 0;
                when = cyc;
                ok   = 1;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1;
        req0 = 0;
        req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, done0, done1, err0, err1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got psel=%b pen=%b pwr=%b d=%b%b e=%b%b want all 0",
                     psel, penable, pwrite, done0, done1, err0, err1);
        end
        checks++;
        if (paddr !== 32'h0 || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got paddr=%h pwdata=%h want 0", paddr, pwdata);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0", rdata0, rdata1);
        end
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_single_write();
        logic [31:0] a = 32'h8000_0000;
        logic [31:0] d = 32'hA5A5_0001;
        fixed_waits = 0;
        @(posedge clk);
        #1;
        drive_port(0, 1, 1, a, d);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (psel !== (k == 1 || k == 2)) begin
                errors++;
                $display("FAIL wr_psel t+%0d got %b", k, psel);
            end
            checks++;
            if (penable !== (k == 2)) begin
                errors++;
                $display("FAIL wr_penable t+%0d got %b", k, penable);
            end
            checks++;
            if (done0 !== (k == 3) || done1 !== 1'b0) begin
                errors++;
                $display("FAIL wr_done t+%0d got done0=%b done1=%b", k, done0, done1);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (pwrite !== 1'b1 || paddr !== a || pwdata !== d) begin
                    errors++;
                    $display("FAIL wr_bus t+%0d got pwrite=%b paddr=%h pwdata=%h want 1 %h %h",
                             k, pwrite, paddr, pwdata, a, d);
                end
            end
            if (k == 3) begin
                checks++;
                if (err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_err got %b want 0", err0);
                end
            end
        end
        exp_mem[a] = d;
        @(posedge clk);
        #1;
        req0 = 0;
    endtask

    task automatic test_single_read();
        logic [31:0] a = 32'h8000_0010;
        slave_mem[a] = 32'h1234_5678;
        exp_mem[a]   = 32'h1234_5678;
        fixed_waits  = 0;
        @(posedge clk);
        #1;
        drive_port(1, 1, 0, a, $urandom);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (psel !== (k == 1 || k == 2) || penable !== (k == 2)) begin
                errors++;
                $display("FAIL rd_psel t+%0d got psel=%b pen=%b", k, psel, penable);
            end
            checks++;
            if (done1 !== (k == 4) || done0 !== 1'b0) begin
                errors++;
                $display("FAIL rd_done t+%0d got done1=%b done0=%b", k, done1, done0);
            end
        end
        checks++;
        if (rdata1 !== exp_lookup(a) || err1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got rdata1=%h err1=%b want %h 0", rdata1, err1, exp_lookup(a));
        end
        checks++;
        if (rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL rd_other got rdata0=%h want 0", rdata0);
        end
        @(posedge clk);
        #1;
        req1 = 0;
    endtask

    task automatic test_wait_states();
        logic [31:0] a = 32'h8000_0004;
        logic [31:0] d = $urandom;
        fixed_waits = 3;
        @(posedge clk);
        #1;
        drive_port(0, 1, 1, a, d);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (psel !== (k >= 1 && k <= 5) || penable !== (k >= 2 && k <= 5)) begin
                errors++;
                $display("FAIL ws_psel t+%0d got psel=%b pen=%b", k, psel, penable);
            end
            checks++;
            if (done0 !== (k == 6)) begin
                errors++;
                $display("FAIL ws_done t+%0d got %b", k, done0);
            end
            if (k >= 1 && k <= 5) begin
                checks++;
                if (paddr !== a || pwdata !== d || pwrite !== 1'b1) begin
                    errors++;
                    $display("FAIL ws_stable t+%0d got %h %h want %h %h", k, paddr, pwdata, a, d);
                end
            end
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL ws_err got %b want 0", err0);
        end
        exp_mem[a] = d;
        @(posedge clk);
        #1;
        req0 = 0;
        fixed_waits = 0;
    endtask

    task automatic test_timeout();
        logic [31:0] a    = 32'h8000_0008;
        logic [31:0] keep = 32'h1234_5678;
        fixed_waits = 1000;
        @(posedge clk);
        #1;
        drive_port(1, 1, 0, a, 0);
        for (int k = 0; k <= TIMEOUT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (psel !== (k >= 1 && k <= TIMEOUT + 1)) begin
                errors++;
                $display("FAIL to_psel t+%0d got %b", k, psel);
            end
            checks++;
            if (done1 !== (k == TIMEOUT + 2)) begin
                errors++;
                $display("FAIL to_done t+%0d got %b", k, done1);
            end
        end
        checks++;
        if (err1 !== 1'b1 || rdata1 !== keep) begin
            errors++;
            $display("FAIL to_err got err1=%b rdata1=%h want 1 %h", err1, rdata1, keep);
        end
        @(posedge clk);
        #1;
        req1 = 0;
        fixed_waits = 0;
        @(negedge clk);
        checks++;
        if (err1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got err1=%b done1=%b want 0 0", err1, done1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a = 32'h8000_000C;
        logic [31:0] d = $urandom;
        bit          seen = 0;
        int          p, when;
        bit          ok;
        fixed_waits = 1000;
        @(posedge clk);
        #1;
        drive_port(0, 1, 1, a, d);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (psel && penable) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_access got no ACCESS within 10 cycles");
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop got psel=%b pen=%b done0=%b want 0", psel, penable, done0);
        end
        @(negedge clk);
        reset = 0;
        fixed_waits = 0;
        @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== a) begin
            errors++;
            $display("FAIL rst_mid_setup got psel=%b pen=%b paddr=%h want 1 0 %h", psel, penable, paddr, a);
        end
        wait_any_done(p, when, ok);
        checks++;
        if (!ok || p != 0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_done got ok=%0d port=%0d err0=%b want 1 0 0", ok, p, err0);
        end
        exp_mem[a] = d;
        @(posedge clk);
        #1;
        req0 = 0;
    endtask

    task automatic test_round_robin();
        logic        pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        logic [31:0] exp_rd [2];
        int exp_owner, idle_start, when, p, exp_when;
        bit ok;
        apply_reset();
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        fixed_waits = -1;
        @(posedge clk);
        #1;
        for (int q = 0; q < 2; q++) begin
            pw[q] = 1'($urandom_range(0, 1));
            pa[q] = 32'h8000_0000 + 32'(4 * $urandom_range(0, 3));
            pd[q] = $urandom;
            drive_port(q, 1, pw[q], pa[q], pd[q]);
        end
        idle_start = cyc;
        exp_owner  = 0;
        for (int n = 0; n < 8; n++) begin
            wait_any_done(p, when, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_wait n=%0d got no done within bound", n);
                break;
            end
            checks++;
            if (p != exp_owner) begin
                errors++;
                $display("FAIL rr_owner n=%0d got port %0d want %0d", n, p, exp_owner);
            end
            exp_when = idle_start + 3 + cur_waits + (pw[p] ? 0 : RD_LAT);
            checks++;
            if (when != exp_when) begin
                errors++;
                $display("FAIL rr_latency n=%0d got cycle %0d want %0d", n, when, exp_when);
            end
            checks++;
            if ((p == 1 ? err1 : err0) !== 1'b0 || (p == 1 ? done0 : done1) !== 1'b0) begin
                errors++;
                $display("FAIL rr_flags n=%0d got err=%b other_done=%b want 0 0",
                         n, (p == 1 ? err1 : err0), (p == 1 ? done0 : done1));
            end
            if (pw[p]) exp_mem[pa[p]] = pd[p];
            else       exp_rd[p] = exp_lookup(pa[p]);
            checks++;
            if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                errors++;
                $display("FAIL rr_rdata n=%0d got %h %h want %h %h", n, rdata0, rdata1, exp_rd[0], exp_rd[1]);
            end
            @(posedge clk);
            #1;
            pw[p] = 1'($urandom_range(0, 1));
            pa[p] = 32'h8000_0000 + 32'(4 * $urandom_range(0, 3));
            pd[p] = $urandom;
            drive_port(p, 1, pw[p], pa[p], pd[p]);
            idle_start = cyc;
            exp_owner  = 1 - exp_owner;
        end
        req0 = 0;
        req1 = 0;
        fixed_waits = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle got psel=%b want 0", psel);
        end
    endtask

    initial begin
        reset = 1;
        drive_port(0, 0, 0, 0, 0);
        drive_port(1, 0, 0, 0, 0);
        test_reset();
        test_single_write();
        test_single_read();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
